// File: rtl/cim_pkg.sv
// Shared constants and FSM state types for the CIM result readout path.
package cim_pkg;

    localparam int NBANK  = 16;
    localparam int PSUM_W = 8;
    localparam int NBITS  = 8;
    localparam int ACC_W  = 16;
    localparam int BANK_W = $clog2(NBANK);
    localparam int CNT_W  = $clog2(NBITS + 1);

    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NBANK - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(NBITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_t;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/cim_bank_acc.sv
// One bank's MSB-first shift-accumulator; sum_nxt exposes the value the
// register would take on an accumulate so completion can bypass a cycle.
module cim_bank_acc #(
    parameter int PW = cim_pkg::PSUM_W,
    parameter int AW = cim_pkg::ACC_W
) (
    input  logic          clk_inv,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic          accum,
    input  logic [PW-1:0] psum,
    output logic [AW-1:0] sum_nxt
);

    logic [AW-1:0] acc_r;
    logic [AW-1:0] psum_ext_s;

    assign psum_ext_s = {{(AW - PW){1'b0}}, psum};
    assign sum_nxt    = {acc_r[AW-2:0], 1'b0} + psum_ext_s;

    // Accumulator register: clear has priority over load, load over accumulate.
    always_ff @(posedge clk_inv or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {AW{1'b0}};
        end else if (clr) begin
            acc_r <= {AW{1'b0}};
        end else if (load) begin
            acc_r <= psum_ext_s;
        end else if (accum) begin
            acc_r <= sum_nxt;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/cim_result_readout.sv
// Accumulates bit-serial per-bank partial sums from the CIM macro on clk_inv
// and streams the finished 16-bank result over a valid/ready handshake.
module cim_result_readout
    import cim_pkg::*;
(
    input  logic                      clk_inv,
    input  logic                      rst_n,
    input  logic                      mac_en_neg,
    input  logic [7:0]                col_mux_neg,
    input  logic [NBANK*PSUM_W-1:0]   psum,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ACC_W-1:0]          res_data,
    output logic [BANK_W-1:0]         res_bank,
    output logic [7:0]                res_col,
    output logic                      res_last,
    output logic                      busy,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    acc_state_t         acc_state_r, acc_state_nxt_s;
    logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]         col_tag_r;
    logic               bank_clr_s, bank_load_s, bank_accum_s, mac_done_s;
    logic [ACC_W-1:0]   sum_nxt_s [NBANK];

    drain_state_t       drain_state_r, drain_state_nxt_s;
    logic               hs_s, last_hs_s;
    logic               buf_load_s, bank_adv_s, drain_end_s, ovf_set_s;
    logic [BANK_W-1:0]  bank_inc_s;
    logic [ACC_W-1:0]   buf_r [NBANK];

    logic               res_valid_r, res_last_r, ovf_r;
    logic [ACC_W-1:0]   res_data_r;
    logic [BANK_W-1:0]  res_bank_r;
    logic [7:0]         res_col_r;

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        cim_bank_acc #(
            .PW (PSUM_W),
            .AW (ACC_W)
        ) u_bank_acc (
            .clk_inv (clk_inv),
            .rst_n   (rst_n),
            .clr     (bank_clr_s),
            .load    (bank_load_s),
            .accum   (bank_accum_s),
            .psum    (psum[g*PSUM_W +: PSUM_W]),
            .sum_nxt (sum_nxt_s[g])
        );
    end

    // Accumulator FSM next state: start, accumulate, complete or abort.
    always_comb begin
        acc_state_nxt_s = acc_state_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        bank_clr_s      = 1'b0;
        bank_load_s     = 1'b0;
        bank_accum_s    = 1'b0;
        mac_done_s      = 1'b0;
        case (acc_state_r)
            IDLE: begin
                if (!mac_en_neg) begin
                    acc_state_nxt_s = ACC;
                    bank_load_s     = 1'b1;
                    bit_cnt_nxt_s   = CNT_W'(1);
                end else begin
                    acc_state_nxt_s = IDLE;
                end
            end
            ACC: begin
                if (mac_en_neg) begin
                    acc_state_nxt_s = IDLE;
                    bank_clr_s      = 1'b1;
                    bit_cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (bit_cnt_r == LAST_BIT) begin
                    // The final psum goes straight to the buffer via sum_nxt.
                    acc_state_nxt_s = IDLE;
                    mac_done_s      = 1'b1;
                    bank_clr_s      = 1'b1;
                    bit_cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    bank_accum_s    = 1'b1;
                    bit_cnt_nxt_s   = bit_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                acc_state_nxt_s = IDLE;
                bank_clr_s      = 1'b1;
                bit_cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Accumulator FSM state, bit counter and column tag registers.
    always_ff @(posedge clk_inv or negedge rst_n) begin
        if (!rst_n) begin
            acc_state_r <= IDLE;
            bit_cnt_r   <= {CNT_W{1'b0}};
            col_tag_r   <= 8'h00;
        end else begin
            acc_state_r <= acc_state_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            if (bank_load_s) begin
                col_tag_r <= col_mux_neg;
            end else begin
                col_tag_r <= col_tag_r;
            end
        end
    end

    assign hs_s       = res_valid_r & res_ready;
    assign last_hs_s  = hs_s & (res_bank_r == LAST_BANK);
    assign bank_inc_s = res_bank_r + BANK_W'(1);

    // Drain FSM next state; a completion landing on the bank-15 handshake reloads.
    always_comb begin
        drain_state_nxt_s = drain_state_r;
        buf_load_s        = 1'b0;
        bank_adv_s        = 1'b0;
        drain_end_s       = 1'b0;
        ovf_set_s         = 1'b0;
        case (drain_state_r)
            EMPTY: begin
                if (mac_done_s) begin
                    drain_state_nxt_s = DRAIN;
                    buf_load_s        = 1'b1;
                end else begin
                    drain_state_nxt_s = EMPTY;
                end
            end
            DRAIN: begin
                if (last_hs_s) begin
                    if (mac_done_s) begin
                        buf_load_s        = 1'b1;
                    end else begin
                        drain_state_nxt_s = EMPTY;
                        drain_end_s       = 1'b1;
                    end
                end else begin
                    bank_adv_s = hs_s;
                    ovf_set_s  = mac_done_s;
                end
            end
            default: begin
                drain_state_nxt_s = EMPTY;
                drain_end_s       = 1'b1;
            end
        endcase
    end

    // Drain FSM state and sticky overflow; a new overflow beats ovf_clr.
    always_ff @(posedge clk_inv or negedge rst_n) begin
        if (!rst_n) begin
            drain_state_r <= EMPTY;
            ovf_r         <= 1'b0;
        end else begin
            drain_state_r <= drain_state_nxt_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Result buffer and registered output word.
    always_ff @(posedge clk_inv or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBANK; k++) begin
                buf_r[k] <= {ACC_W{1'b0}};
            end
            res_valid_r <= 1'b0;
            res_data_r  <= {ACC_W{1'b0}};
            res_bank_r  <= {BANK_W{1'b0}};
            res_col_r   <= 8'h00;
            res_last_r  <= 1'b0;
        end else if (buf_load_s) begin
            for (int k = 0; k < NBANK; k++) begin
                buf_r[k] <= sum_nxt_s[k];
            end
            res_valid_r <= 1'b1;
            res_data_r  <= sum_nxt_s[0];
            res_bank_r  <= {BANK_W{1'b0}};
            res_col_r   <= col_tag_r;
            res_last_r  <= 1'b0;
        end else if (bank_adv_s) begin
            res_data_r  <= buf_r[bank_inc_s];
            res_bank_r  <= bank_inc_s;
            res_last_r  <= (bank_inc_s == LAST_BANK);
        end else if (drain_end_s) begin
            res_valid_r <= 1'b0;
            res_last_r  <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
            res_last_r  <= res_last_r;
        end
    end

    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_bank  = res_bank_r;
    assign res_col   = res_col_r;
    assign res_last  = res_last_r;
    assign busy      = (acc_state_r == ACC);
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_cim_result_readout.sv
// Scoreboard bench for cim_result_readout: expected words are queued as each
// MAC is driven and compared against every presented/accepted output word.
module tb_cim_result_readout;

    logic         clk_inv;
    logic         rst_n;
    logic         mac_en_neg;
    logic [7:0]   col_mux_neg;
    logic [127:0] psum;
    logic         res_valid;
    logic         res_ready;
    logic [15:0]  res_data;
    logic [3:0]   res_bank;
    logic [7:0]   res_col;
    logic         res_last;
    logic         busy;
    logic         ovf;
    logic         ovf_clr;

    logic [28:0]  sb [$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           xfers    = 0;

    cim_result_readout dut (
        .clk_inv     (clk_inv),
        .rst_n       (rst_n),
        .mac_en_neg  (mac_en_neg),
        .col_mux_neg (col_mux_neg),
        .psum        (psum),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_bank    (res_bank),
        .res_col     (res_col),
        .res_last    (res_last),
        .busy        (busy),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    initial begin
        clk_inv = 1'b0;
        forever #5 clk_inv = ~clk_inv;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare the presented word with the scoreboard head, pop on handshake, then advance one edge.
    task automatic step();
        if (res_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'd1, 32'd0);
            end else begin
                check("word", {3'b000, res_data, res_bank, res_col, res_last}, {3'b000, sb[0]});
                if (res_ready) begin
                    void'(sb.pop_front());
                    xfers++;
                end
            end
        end
        @(posedge clk_inv);
        #1;
    endtask

    function automatic logic [7:0] pat(input int mode, input int k, input int b);
        case (mode)
            0:       pat = 8'h01;
            1:       pat = 8'(k);
            2:       pat = 8'hFF;
            default: pat = 8'((k * 37 + b * 91 + 13) ^ (b << 4));
        endcase
    endfunction

    function automatic logic [15:0] exp_val(input int mode, input int k, input logic [15:0] model);
        case (mode)
            0:       exp_val = 16'h00FF;
            1:       exp_val = 16'(k * 255);
            2:       exp_val = 16'hFE01;
            default: exp_val = model;
        endcase
    endfunction

    // Drive one full MAC (8 bits); queue its 16 words unless it is expected to be dropped.
    task automatic do_mac(input logic [7:0] col, input int mode, input bit drop, input bit clr_last);
        logic [15:0] acc [16];
        for (int k = 0; k < 16; k++) acc[k] = 16'h0000;
        mac_en_neg  = 1'b0;
        col_mux_neg = col;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 16; k++) begin
                psum[k*8 +: 8] = pat(mode, k, b);
                acc[k] = (acc[k] << 1) + {8'h00, pat(mode, k, b)};
            end
            if (b == 7) ovf_clr = clr_last;
            if (b == 1) col_mux_neg = ~col;
            step();
        end
        ovf_clr     = 1'b0;
        mac_en_neg  = 1'b1;
        col_mux_neg = 8'h5A;
        psum        = {4{32'hDEADBEEF}};
        if (!drop) begin
            for (int k = 0; k < 16; k++) begin
                sb.push_back({exp_val(mode, k, acc[k]), 4'(k), col, (k == 15)});
            end
        end
    endtask

    task automatic drain_all();
        int n = 0;
        res_ready = 1'b1;
        while ((sb.size() != 0 || res_valid) && n < 200) begin
            step();
            n++;
        end
        check("drain_timeout", {31'd0, (n < 200)}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_data"},  {16'd0, res_data},  32'd0);
        check({tag, "_bank"},  {28'd0, res_bank},  32'd0);
        check({tag, "_col"},   {24'd0, res_col},   32'd0);
        check({tag, "_last"},  {31'd0, res_last},  32'd0);
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
        check({tag, "_ovf"},   {31'd0, ovf},       32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        mac_en_neg  = 1'b1;
        col_mux_neg = 8'h00;
        psum        = 128'd0;
        res_ready   = 1'b0;
        ovf_clr     = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk_inv);
        rst_n = 1'b1;
        @(posedge clk_inv);
        #1;

        // All-ones LSB psum: 0x00FF per bank, result visible one edge after last bit.
        res_ready = 1'b0;
        do_mac(8'hA5, 0, 1'b0, 1'b0);
        check("t1_valid", {31'd0, res_valid}, 32'd1);
        check("t1_busy",  {31'd0, busy},      32'd0);
        drain_all();

        // Bank k gets psum k every bit; ready held high through the drain.
        res_ready = 1'b1;
        do_mac(8'h3C, 1, 1'b0, 1'b0);
        drain_all();
        check("t2_valid_drop", {31'd0, res_valid}, 32'd0);

        // Ready toggling mid-drain: words must hold and all 16 transfer exactly once.
        res_ready = 1'b0;
        do_mac(8'h11, 3, 1'b0, 1'b0);
        xfers = 0;
        for (int i = 0; i < 30; i++) begin
            res_ready = (i % 3 != 1);
            step();
        end
        drain_all();
        check("t3_xfers", 32'(xfers), 32'd16);

        // Abort after 3 bits, then a full 0xFF MAC.
        mac_en_neg = 1'b0;
        col_mux_neg = 8'h77;
        psum = {16{8'h81}};
        for (int i = 0; i < 3; i++) step();
        check("t4_busy_mid", {31'd0, busy}, 32'd1);
        mac_en_neg = 1'b1;
        step();
        check("t4_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("t4_valid", {31'd0, res_valid}, 32'd0);
        check("t4_ovf",   {31'd0, ovf},       32'd0);
        do_mac(8'hC3, 2, 1'b0, 1'b0);
        drain_all();

        // Overflow while banks 5..15 are still undrained; ovf_clr loses to the set.
        res_ready = 1'b1;
        do_mac(8'h01, 1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        res_ready = 1'b0;
        check("t5_bank5", {28'd0, res_bank}, 32'd5);
        do_mac(8'h02, 2, 1'b1, 1'b1);
        check("t5_ovf_set", {31'd0, ovf}, 32'd1);
        drain_all();
        check("t5_ovf_sticky", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t5_ovf_clr", {31'd0, ovf}, 32'd0);

        // Completion coinciding with the bank-15 handshake: no bubble, no overflow.
        res_ready = 1'b1;
        do_mac(8'h44, 1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step();
        do_mac(8'h55, 3, 1'b0, 1'b0);
        check("t6_valid", {31'd0, res_valid}, 32'd1);
        check("t6_bank0", {28'd0, res_bank},  32'd0);
        check("t6_col",   {24'd0, res_col},   32'h55);
        check("t6_ovf",   {31'd0, ovf},       32'd0);
        drain_all();

        // Asynchronous reset in the middle of the drain at bank 7.
        res_ready = 1'b1;
        do_mac(8'h99, 0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        check("t7_bank7", {28'd0, res_bank}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t7_reset");
        sb.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("t7_idle", {31'd0, res_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cim_result_readout.md
Name: cim_result_readout

Overview:
- Return-path counterpart of the negedge input-sync stage for the CIM macro. Runs on clk_inv, alongside the macro.
- Shift-accumulates the bit-serial per-bank partial sums the macro produces while a MAC is active, then holds the 16 finished column results in a buffer.
- Streams the buffered results, one bank per cycle, to the posedge-side consumer over a valid/ready handshake.

Parameters:
- NBANK, 16, number of macro banks; one result per bank.
- PSUM_W, 8, width of each per-bank partial sum from the macro (unsigned).
- NBITS, 8, number of bit-serial input cycles per MAC.
- ACC_W, 16, accumulator/result width; must be >= PSUM_W+NBITS.

Ports:
- clk_inv, input, 1, inverted system clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- mac_en_neg, input, 1, MAC enable from the sync stage; active-low (1 = idle).
- col_mux_neg, input, 8, column select from the sync stage; captured as a tag at MAC start.
- psum, input, NBANK*PSUM_W, packed partial sums; bank k occupies bits [k*PSUM_W +: PSUM_W].
- res_valid, output, 1, the current result word is valid.
- res_ready, input, 1, the consumer accepts the word when res_valid and res_ready are both high on the same edge.
- res_data, output, ACC_W, accumulated result of bank res_bank.
- res_bank, output, 4, bank index of res_data (0..15).
- res_col, output, 8, column tag of the MAC that produced the buffer.
- res_last, output, 1, high with bank 15.
- busy, output, 1, accumulator FSM is not IDLE.
- ovf, output, 1, sticky flag: a completed MAC was dropped because the buffer was full.
- ovf_clr, input, 1, synchronous clear of ovf.

Behaviour:
Reset (rst_n low, asynchronous):
- All accumulators = 0, bit counter = 0.
- res_valid = 0, res_data = 0, res_bank = 0, res_col = 0, res_last = 0.
- busy = 0, ovf = 0.
- Both FSMs return to their idle states.

Accumulator FSM, states IDLE and ACC:
- IDLE -> ACC when mac_en_neg = 0.
  - On this same edge: acc[k] <= psum[k] (first bit, MSB first), col tag <= col_mux_neg, bit counter <= 1.
- In ACC with mac_en_neg = 0: acc[k] <= (acc[k] << 1) + psum[k], counter increments.
  - Unsigned arithmetic, zero-extended to ACC_W, no saturation.
- Completion occurs on the edge that absorbs the NBITS-th partial sum.
  - The final value (including that last psum) is offered to the buffer.
  - FSM returns to IDLE.
  - Latency: the result appears in the buffer one edge after the last psum is presented.
- mac_en_neg = 1 while in ACC: abort. FSM returns to IDLE, accumulators are discarded, nothing reaches the buffer, ovf is unchanged.
- mac_en_neg held low after completion: the next edge starts a new MAC (back-to-back MACs allowed).
- busy = (state == ACC).

Output buffer / drain FSM, states EMPTY and DRAIN:
- Single buffer of NBANK x ACC_W words plus the column tag.
- EMPTY -> DRAIN when a completion is offered.
  - On that edge: load the buffer, res_bank <= 0, res_valid <= 1.
- DRAIN, on each res_valid & res_ready edge: res_bank increments.
  - After bank 15 is accepted: res_valid <= 0 and the FSM goes to EMPTY.
- res_data and res_col are driven from the registered buffer.
- res_data, res_bank and res_col hold stable while res_valid = 1 and res_ready = 0.
- res_last = res_valid & (res_bank == 15).

Boundary cases:
- Completion while DRAIN and bank 15 is accepted on the same edge: the new result loads, the FSM stays in DRAIN with res_bank = 0. No bubble, no ovf.
- Completion while DRAIN otherwise: the result is dropped and ovf <= 1. The buffer is untouched.
- ovf_clr and a new overflow on the same edge: the set wins.
- Reset mid-drain or mid-accumulate: everything returns to reset values immediately. Partial data is lost.

Decomposition:
- Shared package cim_pkg:
  - NBANK, PSUM_W, NBITS, ACC_W defaults.
  - Accumulator state enum (IDLE, ACC) and drain state enum (EMPTY, DRAIN).
  - Bank-index width constant: $clog2(NBANK).
- One sub-module, cim_bank_acc: per-bank shift-accumulate register with load/accumulate/clear controls, instantiated NBANK times by generate.
- Both FSMs, the buffer and the handshake stay in the top level.

Test Plan:
- Reset, then mac_en_neg = 0 for 8 cycles with psum = 8'h01 on all banks:
  - After completion, 16 words each = 16'h00FF, res_col = captured tag, res_last only on bank 15, busy = 0.
- Bank k psum = k on every bit, res_ready held 1:
  - res_data = k*255 for banks 0..15 on consecutive edges.
  - res_valid drops after bank 15.
- res_ready toggling 1-0-1 mid-drain:
  - Outputs hold stable while res_ready = 0.
  - No word is skipped or duplicated; 16 total transfers.
- mac_en_neg deasserted after 3 bits:
  - busy falls, res_valid stays 0, ovf stays 0.
  - The next full MAC with psum = 8'hFF gives 16'hFE01 per bank.
- Second MAC completes while the buffer holds banks 5..15 undrained:
  - ovf = 1 and the old data is still drained intact.
  - ovf_clr clears ovf.
  - Completion coinciding with the bank-15 handshake loads the new result with ovf = 0.
- rst_n pulsed low mid-drain at bank 7: all outputs reach reset values asynchronously.
